// File: rtl/mux6_rr_arbiter.sv
// Round-robin arbiter for six requesters sharing one 6:1 data path, with a
// one-entry valid/ready output register holding the selected word and its select code.
module mux6_rr_arbiter #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned RST_PTR   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [5:0]             req_i,
    input  logic [6*DATAWIDTH-1:0] data_i,
    output logic [5:0]             gnt_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATAWIDTH-1:0]   out_data_o,
    output logic [2:0]             out_sel_o,
    output logic [2:0]             ptr_o
);

    localparam logic [2:0] RstPtr = 3'(RST_PTR);

    logic [2:0]           ptr_q, ptr_d;
    logic                 valid_q, valid_d;
    logic [DATAWIDTH-1:0] data_q, data_d;
    logic [2:0]           sel_q, sel_d;

    logic                 any_req;
    logic                 cap_en;
    logic                 capture;
    logic [2:0]           win;
    logic                 found;
    logic [3:0]           idx;
    logic [DATAWIDTH-1:0] win_data;

    assign any_req = |req_i;
    assign cap_en  = ~valid_q | out_ready_i;
    assign capture = any_req & cap_en;

    // Scan ptr, ptr+1, ... ptr+5 (mod 6); first pending requester wins.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = 4'd0;
        for (int i = 0; i < 6; i++) begin
            idx = {1'b0, ptr_q} + 4'(i);
            if (idx >= 4'd6) begin
                idx = idx - 4'd6;
            end
            if (!found && req_i[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < 6; k++) begin
            if (win == 3'(k)) begin
                win_data = data_i[k*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // Gated by rst_ni so no grant is issued while the register is held in reset.
    always_comb begin
        gnt_o = 6'b000000;
        if (capture && rst_ni) begin
            gnt_o[win] = 1'b1;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (capture) begin
            ptr_d   = (win == 3'd5) ? 3'd0 : win + 3'd1;
            valid_d = 1'b1;
            data_d  = win_data;
            sel_d   = win;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q   <= RstPtr;
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= 3'b000;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_sel_o   = sel_q;
    assign ptr_o       = ptr_q;

endmodule

// File: tb/tb_mux6_rr_arbiter.sv
// Bench for mux6_rr_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level round-robin model.
module tb_mux6_rr_arbiter;

    localparam int unsigned DW      = 32;
    localparam int unsigned RST_PTR = 0;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [5:0]      req;
    logic [6*DW-1:0] data;
    logic [5:0]      gnt;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_sel;
    logic [2:0]      ptr;

    mux6_rr_arbiter #(
        .DATAWIDTH (DW),
        .RST_PTR   (RST_PTR)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .data_i      (data),
        .gnt_o       (gnt),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_sel_o   (out_sel),
        .ptr_o       (ptr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: what the output register and pointer should hold.
    int            m_ptr;
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_sel;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = RST_PTR;
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
    endtask

    function automatic logic [6*DW-1:0] rand_data();
        logic [6*DW-1:0] d;
        for (int k = 0; k < 6; k++) d[k*DW +: DW] = $urandom;
        return d;
    endfunction

    // Drive one cycle's inputs, compare DUT against the model, then advance the model.
    task automatic cycle(input logic [5:0] r, input logic [6*DW-1:0] d, input logic rd);
        int  w;
        bit  cap;
        logic [5:0] exp_gnt;
        @(negedge clk);
        req       = r;
        data      = d;
        out_ready = rd;
        #1;
        check("valid", 64'(out_valid), 64'(m_valid));
        check("data", 64'(out_data), 64'(m_data));
        check("sel", 64'(out_sel), 64'(m_sel));
        check("ptr", 64'(ptr), 64'(m_ptr));
        w = -1;
        for (int off = 0; off < 6; off++) begin
            if (w < 0 && r[(m_ptr + off) % 6]) w = (m_ptr + off) % 6;
        end
        cap     = (w >= 0) && (!m_valid || rd);
        exp_gnt = cap ? 6'(1 << w) : 6'd0;
        check("gnt", 64'(gnt), 64'(exp_gnt));
        if (cap) begin
            m_data  = d[w*DW +: DW];
            m_sel   = w;
            m_valid = 1'b1;
            m_ptr   = (w + 1) % 6;
        end else if (m_valid && rd) begin
            m_valid = 1'b0;
        end
    endtask

    // Asynchronous reset with requests pending; leaves req idle before release.
    task automatic do_reset();
        @(negedge clk);
        req       = 6'h3f;
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_sel", 64'(out_sel), 64'd0);
        check("rst_ptr", 64'(ptr), 64'(RST_PTR));
        check("rst_gnt", 64'(gnt), 64'd0);
        @(negedge clk);
        #1;
        check("rst_gnt_hold", 64'(gnt), 64'd0);
        req = 6'h00;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    logic [6*DW-1:0] d;

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        data      = '0;
        out_ready = 1'b0;
        model_reset();
        #12;
        rst_n = 1'b1;

        // All requesting, always ready: grants rotate 0..5 then back to 0.
        do_reset();
        d = rand_data();
        for (int i = 0; i < 7; i++) begin
            cycle(6'h3f, d, 1'b1);
            check("rot_gnt", 64'(gnt), 64'(1 << (i % 6)));
        end

        // Single requester 3 with a known word.
        do_reset();
        d = rand_data();
        d[3*DW +: DW] = 32'hDEADBEEF;
        cycle(6'b001000, d, 1'b1);
        check("r3_gnt", 64'(gnt), 64'h08);
        cycle(6'b000000, d, 1'b1);
        check("r3_data", 64'(out_data), 64'hDEADBEEF);
        check("r3_sel", 64'(out_sel), 64'd3);
        check("r3_ptr", 64'(ptr), 64'd4);

        // Move ptr to 5, then requesters 5 and 0 contend: 5 wins, ptr wraps.
        cycle(6'b010000, d, 1'b1);
        cycle(6'b100001, d, 1'b1);
        check("wrap_gnt5", 64'(gnt), 64'h20);
        cycle(6'b000001, d, 1'b1);
        check("wrap_gnt0", 64'(gnt), 64'h01);

        // Stall then release: drain and refill in one cycle.
        d = rand_data();
        for (int i = 0; i < 5; i++) cycle(6'b000110, d, 1'b0);
        cycle(6'b000110, d, 1'b1);
        cycle(6'b000110, d, 1'b1);
        cycle(6'b000000, d, 1'b1);
        cycle(6'b000000, d, 1'b1);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [5:0] r;
            r = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
            cycle(r, rand_data(), 1'($urandom_range(0, 2) != 0));
        end

        // Reset while a word is held and requests are pending, then resume.
        for (int i = 0; i < 3; i++) cycle(6'h3f, rand_data(), 1'b0);
        do_reset();
        for (int i = 0; i < 20; i++) cycle(6'($urandom), rand_data(), 1'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux6_rr_arbiter.md
Name: mux6_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 6:1 data-select path among six requesters.
- Chooses one pending requester per cycle and drives the 3-bit select code.
- Captures the selected word into a one-entry output register and presents it downstream with a valid/ready handshake.
- Sits in front of shared writeback/bus paths where up to six sources contend for a single DATAWIDTH-wide sink.

Parameters:
- DATAWIDTH, 32: width of each requester data word and of the output.
- RST_PTR, 0: initial round-robin priority pointer (0..5); the requester checked first after reset.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_i  input  6  per-requester request; bit k belongs to requester k.
- data_i  input  6*DATAWIDTH  packed requester data; requester k occupies bits [k*DATAWIDTH +: DATAWIDTH].
- gnt_o  output  6  one-hot grant; combinational; asserted in the capture cycle only.
- out_valid_o  output  1  output register holds a word.
- out_ready_i  input  1  downstream accepts the word this cycle.
- out_data_o  output  DATAWIDTH  registered data word.
- out_sel_o  output  3  registered select code (000..101) of the requester that produced out_data_o.
- ptr_o  output  3  current round-robin pointer (debug/verification).

Behaviour:
- **Reset (asynchronous, rst_ni=0):**
  - out_valid_o=0, out_data_o=0, out_sel_o=3'b000, ptr_o=RST_PTR.
  - gnt_o=0 while in reset.
  - Reset mid-transfer discards the held word; no grant is issued for it.
- **Capture enable:** cap_en = ~out_valid_o | out_ready_i. The output register accepts a new word whenever it is empty or is being drained in the same cycle.
- **Arbitration (combinational):**
  - Search order: ptr, ptr+1, …, ptr+5, all mod 6.
  - Winner w is the first index k in that order with req_i[k]=1.
  - any_req = |req_i.
- **Grant:**
  - gnt_o[w] = any_req & cap_en; all other bits are 0.
  - gnt_o is never multi-hot and never asserts when req_i=0.
- **Capture edge (any_req & cap_en):**
  - out_data_o <= data_i[w]; out_sel_o <= w; out_valid_o <= 1.
  - ptr <= (w==5) ? 0 : w+1. The pointer wraps 5 -> 0 and only advances on a grant.
- **Drain without refill (out_valid_o & out_ready_i & ~any_req):**
  - out_valid_o <= 0.
  - out_data_o and out_sel_o hold their last values.
- **Stall (out_valid_o & ~out_ready_i):**
  - out_data_o, out_sel_o, ptr and out_valid_o all hold.
  - gnt_o=0.
- **Throughput and latency:**
  - Back-to-back handshakes give 1 word per cycle.
  - Latency from request to out_valid_o is 1 cycle when the register is free.
- **Requester contract:**
  - Requester k holds req_i[k] and its data stable until it samples gnt_o[k]=1. The word is consumed at that edge.
  - Dropping req before grant is legal; that requester is simply skipped.
- **Fairness:** a continuously asserting requester is granted within 6 captures.
- **Output contract:** out_ready_i while out_valid_o=0 has no effect.
- **Select encoding:** codes 110/111 are never produced.

Test Plan:
- Reset with req_i=6'b111111, out_ready_i=1, release reset -> grants in order 0,1,2,3,4,5,0 on consecutive cycles; out_sel_o follows one cycle later; ptr_o after the 6th grant = 0.
- Only req_i[3]=1 with data 0xDEADBEEF, out_ready_i=1 -> gnt_o=6'b001000 in the first cycle; next cycle out_valid_o=1, out_data_o=0xDEADBEEF, out_sel_o=3; ptr_o=4.
- req_i=6'b100001 with ptr=5 -> requester 5 wins (gnt_o=6'b100000); ptr wraps to 0; next grant goes to requester 0.
- Output stalled (out_ready_i=0 for 4 cycles, req_i=6'b000110) -> gnt_o=0 throughout; out_data_o stable; on out_ready_i=1, drain and capture occur in the same cycle, out_valid_o stays 1, and the next requester is granted.
- out_valid_o=1, out_ready_i=1, req_i=0 -> out_valid_o falls to 0 next cycle; ptr unchanged; gnt_o=0.
- Assert rst_ni=0 while out_valid_o=1 and requests pending -> immediately out_valid_o=0, out_data_o=0, ptr_o=RST_PTR, gnt_o=0; normal arbitration resumes on the first edge after release.
